// File: rtl/serial_seq_ctrl.sv
// Word-to-serial sequencer for a run-of-ones detector: flush bit, WIDTH data bits, hit collection.
// Optional build macro SERIAL_SEQ_MSB_FIRST_EN shifts the word MSB first (default LSB first).
module serial_seq_ctrl #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 5,
  parameter int IDX_W   = 4,
  parameter int DET_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             det_stream,
  output logic             det_valid,
  input  logic             det_hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [IDX_W-1:0] first_idx,
  output logic             first_valid
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;

  localparam int SW = $clog2(WIDTH + DET_LAT + 1);
  localparam logic [SW-1:0] S_LASTBIT = SW'(WIDTH - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(WIDTH + DET_LAT - 1);
  localparam logic [SW-1:0] S_LAT     = SW'(DET_LAT);

  state_t           state, state_nxt;
  logic [SW-1:0]    s;
  logic [WIDTH-1:0] sreg, sreg_shifted;
  logic             sbit;
  logic             busy_d, done_d, det_valid_d, det_stream_d;
  logic             in_win;
  logic [SW-1:0]    rel;
  logic [IDX_W-1:0] idx;

`ifdef SERIAL_SEQ_MSB_FIRST_EN
  assign sbit         = sreg[WIDTH-1];
  assign sreg_shifted = sreg << 1;
  assign idx          = IDX_W'(S_LASTBIT - rel);
`else
  assign sbit         = sreg[0];
  assign sreg_shifted = sreg >> 1;
  assign idx          = IDX_W'(rel);
`endif

  // s is the sample index: 0 on the first SHIFT cycle, running through DRAIN
  assign rel    = s - S_LAT;
  assign in_win = (state == SHIFT || state == DRAIN) && (s >= S_LAT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (s == S_LASTBIT) state_nxt = (DET_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (s == S_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from the next state so the registered copies line up with state
  always_comb begin
    busy_d       = (state_nxt != IDLE);
    done_d       = (state_nxt == DONE);
    det_valid_d  = (state_nxt == LOAD) || (state_nxt == SHIFT);
    det_stream_d = (state_nxt == SHIFT) && sbit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      det_valid   <= 1'b0;
      det_stream  <= 1'b0;
      sreg        <= '0;
      s           <= '0;
      hit_cnt     <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      det_valid  <= det_valid_d;
      det_stream <= det_stream_d;

      if (state == IDLE && start) sreg <= din;
      else if (state_nxt == SHIFT) sreg <= sreg_shifted;

      if (state == LOAD) s <= '0;
      else if (state == SHIFT || state == DRAIN) s <= s + 1'b1;

      if (state == IDLE && start) begin
        hit_cnt     <= '0;
        first_idx   <= '0;
        first_valid <= 1'b0;
      end else if (in_win && det_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        if (!first_valid) begin
          first_idx   <= idx;
          first_valid <= 1'b1;
        end
      end
    end
  end
endmodule
